nms_datapath: RTL and testbench
===============================

Name: nms_datapath

Overview:
- Datapath partner of the NMS sequencing FSM.
- Consumes the FSM's per-cycle neighbour index (adjNumber), register-file write index (regAddr) and compare strobe (readen).
- Fetches nine FAST scores (8 neighbours + centre) from the score memory into a 9-entry register file, then performs the non-maximum-suppression compare.
- Emits one corner/no-corner result per window to the downstream corner writer.

Parameters:
- WIDTH, 300, image width in pixels (row stride of score memory).
- CENTER_LAG, 302, distance from streaming refAddr back to window centre address.
- SCORE_W, 8, score bit width.

Ports:
- clock  in  1  system clock
- nReset  in  1  asynchronous active-low reset
- refAddr  in  15  current streaming pixel address
- adjNumber  in  4  neighbour index to fetch; 0..8 valid, else no fetch
- regAddr  in  4  register-file write index; 0..8 valid
- readen  in  1  single-cycle compare strobe
- memAddr  out  15  score memory read address
- memRen  out  1  score memory read enable
- memData  in  SCORE_W  score memory read data, 1-cycle synchronous latency
- nmsValid  out  1  one-cycle result strobe
- nmsCorner  out  1  centre survives NMS
- nmsAddr  out  15  centre address of the reported window
- nmsScore  out  SCORE_W  centre score of the reported window
- cornerCount  out  16  saturating count of surviving corners
- seqErr  out  1  sticky; regAddr disagreed with the fetch pipeline

Behaviour:
- Reset state (nReset low, async):
  - memAddr=0, memRen=0, nmsValid=0, nmsCorner=0, nmsAddr=0, nmsScore=0, cornerCount=0, seqErr=0.
  - Register file reg[0..8] cleared; pipeline valid bits cleared.
- Centre latch: in the cycle adjNumber==0, centreAddr <= refAddr - CENTER_LAG (mod 2^15). It holds for the whole window; refAddr changes mid-window are ignored.
- Offsets for adjNumber 0..8 (added to centreAddr, mod 2^15), W=WIDTH:
  - 0: -W-1
  - 1: -W
  - 2: -W+1
  - 3: -1
  - 4: +1
  - 5: +W-1
  - 6: +W
  - 7: +W+1
  - 8: 0 (centre)
  - For adjNumber 0 the address uses the freshly computed centre, not the stale latch.
- Fetch stage 1 (registered):
  - adjNumber in 0..8: memAddr <= centre+offset, memRen <= 1, idx1 <= adjNumber, v1 <= 1.
  - Otherwise (9..15 or X): memRen <= 0, v1 <= 0; memAddr holds.
- Fetch stage 2: memData is valid one cycle after memRen; v2 <= v1, idx2 <= idx1.
- Register-file write:
  - Occurs in the cycle v2==1: reg[regAddr] <= memData. Total latency adjNumber -> write = 2 cycles.
  - If regAddr != idx2 or regAddr > 8 while v2==1: no write, seqErr <= 1 (sticky until reset).
  - No write when v2==0, regardless of regAddr.
- Compare, on readen==1 (registered, results valid the next cycle):
  - c = reg[8].
  - nmsCorner = (c != 0) && c > reg[0..3] && c >= reg[4..7]. Ties go to the earlier-scanned pixel.
  - nmsValid pulses 1 for exactly one cycle. nmsAddr = centreAddr, nmsScore = c.
  - cornerCount increments when nmsCorner=1; saturates at 16'hFFFF.
- readen in the same cycle as a register-file write: compare uses pre-write contents.
- Back-to-back readen: one result per strobe.
- Outputs hold their last values between strobes; nmsValid returns to 0.
- Register file is not cleared between windows; stale entries are overwritten by the next window's fetch.
- Border columns are not detected here. Upstream scoring writes 0 on the image border, so row wrap-around in neighbour addresses is harmless.
- Reset mid-window: all state returns to reset values immediately. The next window restarts cleanly at adjNumber==0.

Test Plan:
- Reset, then drive a full window at refAddr=1000 with adjNumber 0..8 (regAddr two cycles behind).
  - Required: memAddr sequence 397,398,399,697,699,997,998,999,698 with memRen=1.
  - Required: reg[k] captures memory contents; seqErr=0.
- Centre score 50, neighbours 10..17, readen -> next cycle nmsValid=1, nmsCorner=1, nmsAddr=698, nmsScore=50, cornerCount=1.
- Tie cases:
  - Centre 40, reg[6]=40 -> nmsCorner=1.
  - Centre 40, reg[2]=40 -> nmsCorner=0.
  - Centre 0, all neighbours 0 -> nmsCorner=0.
- Inject regAddr=5 while idx2=4 -> no register write, seqErr=1, and seqErr stays 1 across further windows until nReset.
- Assert nReset low mid-window (after adjNumber=4) -> all outputs 0 asynchronously. The next full window yields a correct result with no residue from the aborted window.
- Force cornerCount to 16'hFFFE, then run three corner windows -> count reads FFFF, FFFF, FFFF (saturates).

Source files
------------

// File: rtl/nms_if.sv
// Datapath-side bundle of the NMS block: sequencing inputs, score memory port and result outputs.
interface nms_if #(
  parameter int SCORE_W = 8
);
  logic [14:0]        refAddr;
  logic [3:0]         adjNumber;
  logic [3:0]         regAddr;
  logic               readen;
  logic [14:0]        memAddr;
  logic               memRen;
  logic [SCORE_W-1:0] memData;
  logic               nmsValid;
  logic               nmsCorner;
  logic [14:0]        nmsAddr;
  logic [SCORE_W-1:0] nmsScore;
  logic [15:0]        cornerCount;
  logic               seqErr;

  modport master (
    output refAddr, adjNumber, regAddr, readen, memData,
    input  memAddr, memRen, nmsValid, nmsCorner, nmsAddr, nmsScore, cornerCount, seqErr
  );

  modport slave (
    input  refAddr, adjNumber, regAddr, readen, memData,
    output memAddr, memRen, nmsValid, nmsCorner, nmsAddr, nmsScore, cornerCount, seqErr
  );
endinterface

// File: rtl/nms_datapath.sv
// NMS datapath: fetches a 3x3 score window into a 9-entry register file and compares the centre.
// Fetch-to-write latency 2 cycles; compare result one cycle after readen.
module nms_datapath #(
  parameter int WIDTH      = 300,
  parameter int CENTER_LAG = 302,
  parameter int SCORE_W    = 8
) (
  input  logic   clock,
  input  logic   nReset,
  nms_if.slave   bus
);

  localparam logic [14:0] W15 = 15'(WIDTH);

  logic [14:0]        centre_q, centre_d;
  logic [14:0]        off_d;
  logic [14:0]        mem_addr_q;
  logic               mem_ren_q;
  logic               v1_q, v2_q;
  logic [3:0]         idx1_q, idx2_q;
  logic [SCORE_W-1:0] rf_q [0:8];
  logic               valid_q, corner_q, seq_err_q;
  logic [14:0]        addr_q;
  logic [SCORE_W-1:0] score_q;
  logic [15:0]        cnt_q;
  logic               fetch_ok, wr_err, win;

  assign fetch_ok = (bus.adjNumber <= 4'd8);
  assign wr_err   = v2_q && ((bus.regAddr != idx2_q) || (bus.regAddr > 4'd8));

  // Address for adjNumber 0 must use the fresh centre, not the stale latch.
  always_comb begin
    centre_d = centre_q;
    if (bus.adjNumber == 4'd0) centre_d = bus.refAddr - 15'(CENTER_LAG);
    off_d = 15'd0;
    case (bus.adjNumber)
      4'd0: off_d = 15'd0 - W15 - 15'd1;
      4'd1: off_d = 15'd0 - W15;
      4'd2: off_d = 15'd0 - W15 + 15'd1;
      4'd3: off_d = 15'h7FFF;
      4'd4: off_d = 15'd1;
      4'd5: off_d = W15 - 15'd1;
      4'd6: off_d = W15;
      4'd7: off_d = W15 + 15'd1;
      default: off_d = 15'd0;
    endcase
  end

  // Earlier-scanned neighbours (0..3) win ties; later ones (4..7) lose them.
  always_comb begin
    win = (rf_q[8] != '0);
    for (int i = 0; i < 4; i++) if (!(rf_q[8] > rf_q[i])) win = 1'b0;
    for (int i = 4; i < 8; i++) if (!(rf_q[8] >= rf_q[i])) win = 1'b0;
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      centre_q   <= '0;
      mem_addr_q <= '0;
      mem_ren_q  <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      idx1_q     <= '0;
      idx2_q     <= '0;
      for (int i = 0; i < 9; i++) rf_q[i] <= '0;
      valid_q    <= 1'b0;
      corner_q   <= 1'b0;
      addr_q     <= '0;
      score_q    <= '0;
      cnt_q      <= '0;
      seq_err_q  <= 1'b0;
    end else begin
      centre_q <= centre_d;
      v1_q     <= fetch_ok;
      mem_ren_q <= fetch_ok;
      if (fetch_ok) begin
        mem_addr_q <= centre_d + off_d;
        idx1_q     <= bus.adjNumber;
      end
      v2_q   <= v1_q;
      idx2_q <= idx1_q;
      if (wr_err) seq_err_q <= 1'b1;
      else if (v2_q) rf_q[bus.regAddr] <= bus.memData;
      valid_q <= bus.readen;
      if (bus.readen) begin
        corner_q <= win;
        addr_q   <= centre_q;
        score_q  <= rf_q[8];
        if (win && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign bus.memAddr     = mem_addr_q;
  assign bus.memRen      = mem_ren_q;
  assign bus.nmsValid    = valid_q;
  assign bus.nmsCorner   = corner_q;
  assign bus.nmsAddr     = addr_q;
  assign bus.nmsScore    = score_q;
  assign bus.cornerCount = cnt_q;
  assign bus.seqErr      = seq_err_q;

endmodule

// File: tb/tb_nms_datapath.sv
// Self-checking bench for nms_datapath: table vectors, random windows, sticky error, reset abort, saturation.
module tb_nms_datapath;
  logic clock = 1'b0;
  logic nReset = 1'b0;
  always #5 clock = ~clock;

  nms_if #(.SCORE_W(8)) bus ();
  nms_datapath #(.WIDTH(300), .CENTER_LAG(302), .SCORE_W(8)) dut (
    .clock(clock), .nReset(nReset), .bus(bus)
  );

  logic [7:0] mem [0:32767];
  always @(posedge clock) if (bus.memRen) bus.memData <= mem[bus.memAddr];

  int chk_cnt = 0;
  int pass_cnt = 0;
  int exp_cnt = 0;
  bit exp_seq = 0;

  typedef struct {
    logic [7:0] c;
    logic [7:0] base;
    int         tie_idx;
    logic [7:0] tie_val;
    bit         exp_c;
  } vec_t;
  vec_t vecs [0:6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit ref_corner(input logic [8:0][7:0] sc);
    bit ok = (sc[8] != 0);
    for (int k = 0; k < 8; k++)
      if (k < 4 ? !(sc[k] < sc[8]) : !(sc[k] <= sc[8])) ok = 0;
    return ok;
  endfunction

  // Runs one window; bad >= 0 misaddresses that index's write, abort >= 0 resets after that adjNumber.
  task automatic run_window(input logic [14:0] ra, input logic [8:0][7:0] sc,
                            input int bad, input int abort, input bit exp_c);
    int dy [0:8] = '{-1, -1, -1, 0, 0, 1, 1, 1, 0};
    int dx [0:8] = '{-1, 0, 1, -1, 1, -1, 0, 1, 0};
    logic [14:0] centre, addr [0:8];
    centre = ra - 15'd302;
    for (int k = 0; k < 9; k++) begin
      addr[k] = 15'(int'(centre) + dy[k] * 300 + dx[k]);
      mem[addr[k]] = sc[k];
    end
    for (int n = 0; n <= 10; n++) begin
      @(negedge clock);
      if (n >= 1 && n <= 9) begin
        chk("memAddr", 32'(bus.memAddr), 32'(addr[n-1]));
        chk("memRen", 32'(bus.memRen), 32'd1);
      end
      if (n == 10) chk("memRen_idle", 32'(bus.memRen), 32'd0);
      bus.adjNumber = (n <= 8) ? 4'(n) : 4'hF;
      bus.refAddr   = (n == 0) ? ra : 15'($urandom);
      bus.regAddr   = (n >= 2) ? 4'(n - 2) : 4'hF;
      if (bad >= 0 && n - 2 == bad) begin
        bus.regAddr = 4'(bad + 1);
        exp_seq = 1;
      end
      if (n == abort) begin
        #2 nReset = 1'b0;
        #1;
        chk("rst_memAddr", 32'(bus.memAddr), 32'd0);
        chk("rst_memRen", 32'(bus.memRen), 32'd0);
        chk("rst_valid", 32'(bus.nmsValid), 32'd0);
        chk("rst_corner", 32'(bus.nmsCorner), 32'd0);
        chk("rst_addr", 32'(bus.nmsAddr), 32'd0);
        chk("rst_score", 32'(bus.nmsScore), 32'd0);
        chk("rst_count", 32'(bus.cornerCount), 32'd0);
        chk("rst_seqErr", 32'(bus.seqErr), 32'd0);
        exp_cnt = 0;
        exp_seq = 0;
        bus.adjNumber = 4'hF;
        bus.regAddr = 4'hF;
        @(negedge clock);
        nReset = 1'b1;
        return;
      end
    end
    @(negedge clock);
    bus.adjNumber = 4'hF;
    bus.regAddr = 4'hF;
    bus.readen = 1'b1;
    @(negedge clock);
    bus.readen = 1'b0;
    if (exp_c && exp_cnt < 65535) exp_cnt++;
    chk("nmsValid", 32'(bus.nmsValid), 32'd1);
    chk("nmsCorner", 32'(bus.nmsCorner), 32'(exp_c));
    chk("nmsAddr", 32'(bus.nmsAddr), 32'(centre));
    chk("nmsScore", 32'(bus.nmsScore), 32'(sc[8]));
    chk("cornerCount", 32'(bus.cornerCount), 32'(exp_cnt));
    chk("seqErr", 32'(bus.seqErr), 32'(exp_seq));
    @(negedge clock);
    chk("nmsValid_drop", 32'(bus.nmsValid), 32'd0);
    chk("nmsScore_hold", 32'(bus.nmsScore), 32'(sc[8]));
  endtask

  initial begin
    logic [8:0][7:0] sc;
    bit e;
    vecs[0] = '{c: 8'd50,  base: 8'd10,  tie_idx: -2, tie_val: 8'd0,  exp_c: 1'b1};
    vecs[1] = '{c: 8'd40,  base: 8'd5,   tie_idx: 6,  tie_val: 8'd40, exp_c: 1'b1};
    vecs[2] = '{c: 8'd40,  base: 8'd5,   tie_idx: 2,  tie_val: 8'd40, exp_c: 1'b0};
    vecs[3] = '{c: 8'd0,   base: 8'd0,   tie_idx: -1, tie_val: 8'd0,  exp_c: 1'b0};
    vecs[4] = '{c: 8'd40,  base: 8'd5,   tie_idx: 3,  tie_val: 8'd41, exp_c: 1'b0};
    vecs[5] = '{c: 8'd255, base: 8'd254, tie_idx: -1, tie_val: 8'd0,  exp_c: 1'b1};
    vecs[6] = '{c: 8'd9,   base: 8'd1,   tie_idx: 7,  tie_val: 8'd10, exp_c: 1'b0};

    bus.refAddr = '0; bus.adjNumber = 4'hF; bus.regAddr = 4'hF; bus.readen = 1'b0; bus.memData = '0;
    repeat (2) @(negedge clock);
    chk("reset_valid", 32'(bus.nmsValid), 32'd0);
    chk("reset_count", 32'(bus.cornerCount), 32'd0);
    chk("reset_seqErr", 32'(bus.seqErr), 32'd0);
    chk("reset_memRen", 32'(bus.memRen), 32'd0);
    nReset = 1'b1;
    @(negedge clock);

    // Table vectors; -2 tie index means ascending neighbours base+k.
    for (int v = 0; v < 7; v++) begin
      sc[8] = vecs[v].c;
      for (int k = 0; k < 8; k++)
        sc[k] = (vecs[v].tie_idx == -2) ? vecs[v].base + 8'(k) : vecs[v].base;
      if (vecs[v].tie_idx >= 0) sc[vecs[v].tie_idx] = vecs[v].tie_val;
      run_window(15'd1000, sc, -1, -1, vecs[v].exp_c);
    end

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 8; k++) sc[k] = 8'($urandom_range(0, 12));
      sc[8] = 8'($urandom_range(0, 14));
      e = ref_corner(sc);
      run_window(15'($urandom), sc, -1, -1, e);
    end

    // Misaddressed write of index 4 leaves the stale 14 in place, so centre 100 still wins.
    sc[8] = 8'd50;
    for (int k = 0; k < 8; k++) sc[k] = 8'd10 + 8'(k);
    run_window(15'd2000, sc, -1, -1, 1'b1);
    sc[8] = 8'd100;
    for (int k = 0; k < 8; k++) sc[k] = 8'd20;
    sc[4] = 8'd200;
    run_window(15'd3000, sc, 4, -1, 1'b1);
    for (int k = 0; k < 8; k++) sc[k] = 8'd20;
    run_window(15'd4000, sc, -1, -1, 1'b1);

    for (int k = 0; k < 9; k++) sc[k] = 8'd99;
    run_window(15'd5000, sc, -1, 4, 1'b0);
    sc[8] = 8'd30;
    for (int k = 0; k < 8; k++) sc[k] = 8'd3 + 8'(k);
    run_window(15'd6000, sc, -1, -1, 1'b1);

    // Back-to-back strobes on the same corner window drive the counter to saturation.
    @(negedge clock);
    bus.readen = 1'b1;
    while (exp_cnt < 16'hFFFE) begin
      @(negedge clock);
      exp_cnt++;
    end
    bus.readen = 1'b0;
    chk("b2b_valid", 32'(bus.nmsValid), 32'd1);
    chk("count_fffe", 32'(bus.cornerCount), 32'hFFFE);
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      bus.readen = 1'b1;
      @(negedge clock);
      bus.readen = 1'b0;
      chk("sat_valid", 32'(bus.nmsValid), 32'd1);
      chk("sat_count", 32'(bus.cornerCount), 32'hFFFF);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
